ram_port_arbiter: RTL and testbench

Two-requester arbiter and sequencer for the single shared RAM read/write port of `rvcpu`. It accepts fetch reads from the IFU and load/store requests from the LSU, then serialises them onto the one `ram_rw_*` port. It registers each request and drives the port for exactly one cycle. It then waits for the memory's registered ready and returns data, ready and error status to the granting requester. It sits inside `rvcpu`, between IFU/LSU and the top-level RAM port.

---
 rtl/ram_port_arbiter_pkg.sv | 19 +
 rtl/ram_port_arbiter_if.sv | 46 ++++
 rtl/rr_pick2.sv | 22 ++
 rtl/ram_port_arbiter.sv | 130 +++++++++++++
 tb/tb_ram_port_arbiter.sv | 285 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ram_port_arbiter_pkg.sv
// Shared definitions for the RAM port arbiter: FSM states, owner codes and
// the size code that instruction fetches always use.
package ram_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_REQ  = 2'd1,
    ARB_WAIT = 2'd2
  } arb_state_e;

  typedef enum logic {
    ARB_OWN_IFU = 1'b0,
    ARB_OWN_LSU = 1'b1
  } arb_owner_e;

  // Fetches are always full doubleword reads.
  localparam logic [2:0] ARB_SIZE_DWORD = 3'd3;

endpackage

// File: rtl/ram_port_arbiter_if.sv
// Bundle of the IFU, LSU and RAM-side signals around the RAM port arbiter.
// slave: the arbiter's view; master: the surrounding requesters and memory.
interface ram_port_arbiter_if;

  logic        ifu_valid_i;
  logic [63:0] ifu_addr_i;
  logic        ifu_ready_o;
  logic [63:0] ifu_data_o;
  logic        ifu_err_o;

  logic        lsu_valid_i;
  logic        lsu_wen_i;
  logic [63:0] lsu_addr_i;
  logic [63:0] lsu_wdata_i;
  logic [2:0]  lsu_size_i;
  logic        lsu_ready_o;
  logic [63:0] lsu_data_o;
  logic        lsu_err_o;

  logic        ram_rw_cen_o;
  logic        ram_rw_wen_o;
  logic [63:0] ram_rw_addr_o;
  logic [63:0] ram_rw_wdata_o;
  logic [2:0]  ram_rw_size_o;
  logic        ram_rw_ready_i;
  logic [63:0] ram_rw_data_i;

  modport slave (
    input  ifu_valid_i, ifu_addr_i,
    output ifu_ready_o, ifu_data_o, ifu_err_o,
    input  lsu_valid_i, lsu_wen_i, lsu_addr_i, lsu_wdata_i, lsu_size_i,
    output lsu_ready_o, lsu_data_o, lsu_err_o,
    output ram_rw_cen_o, ram_rw_wen_o, ram_rw_addr_o, ram_rw_wdata_o, ram_rw_size_o,
    input  ram_rw_ready_i, ram_rw_data_i
  );

  modport master (
    output ifu_valid_i, ifu_addr_i,
    input  ifu_ready_o, ifu_data_o, ifu_err_o,
    output lsu_valid_i, lsu_wen_i, lsu_addr_i, lsu_wdata_i, lsu_size_i,
    input  lsu_ready_o, lsu_data_o, lsu_err_o,
    input  ram_rw_cen_o, ram_rw_wen_o, ram_rw_addr_o, ram_rw_wdata_o, ram_rw_size_o,
    output ram_rw_ready_i, ram_rw_data_i
  );

endinterface

// File: rtl/rr_pick2.sv
// Two-way round-robin picker: a lone request wins, a conflict goes to the
// requester that was not granted last. grant is the winning index.
module rr_pick2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic       grant,
  output logic       any
);

  // Pick the winner from the request pair and the previous grant.
  always_comb begin
    any   = |req;
    grant = 1'b0;
    case (req)
      2'b01:   grant = 1'b0;
      2'b10:   grant = 1'b1;
      2'b11:   grant = ~last;
      default: grant = 1'b0;
    endcase
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// Serialises IFU fetches and LSU loads/stores onto the single RAM port:
// latch the winner's request, drive the port for one cycle, then wait for
// the memory's ready (or a timeout) and return the result to the owner.
module ram_port_arbiter
  import ram_port_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  ram_port_arbiter_if.slave bus
);

  arb_state_e  state_q, state_d;
  arb_owner_e  owner_q, last_grant_q, pick_owner;
  logic        wen_q;
  logic [63:0] addr_q;
  logic [63:0] wdata_q;
  logic [2:0]  size_q;
  logic [7:0]  cnt_q;
  logic        pick_grant, pick_any;
  logic        timeout_hit;
  logic        done;
  logic        err;
  logic [63:0] rdata;

  rr_pick2 u_pick (
    .req   ({bus.lsu_valid_i, bus.ifu_valid_i}),
    .last  (last_grant_q == ARB_OWN_LSU),
    .grant (pick_grant),
    .any   (pick_any)
  );

  assign pick_owner  = pick_grant ? ARB_OWN_LSU : ARB_OWN_IFU;
  assign timeout_hit = (cnt_q == 8'(TIMEOUT - 1));

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= ARB_IDLE;
    else        state_q <= state_d;
  end

  // Request latch, grant history and WAIT-cycle counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      owner_q      <= ARB_OWN_IFU;
      last_grant_q <= ARB_OWN_IFU;
      wen_q        <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      size_q       <= '0;
      cnt_q        <= '0;
    end else begin
      case (state_q)
        ARB_IDLE: begin
          if (pick_any) begin
            owner_q      <= pick_owner;
            last_grant_q <= pick_owner;
            if (pick_owner == ARB_OWN_LSU) begin
              wen_q   <= bus.lsu_wen_i;
              addr_q  <= bus.lsu_addr_i;
              wdata_q <= bus.lsu_wdata_i;
              size_q  <= bus.lsu_size_i;
            end else begin
              wen_q   <= 1'b0;
              addr_q  <= bus.ifu_addr_i;
              wdata_q <= '0;
              size_q  <= ARB_SIZE_DWORD;
            end
          end
        end
        ARB_REQ:  cnt_q <= '0;
        ARB_WAIT: cnt_q <= cnt_q + 8'd1;
        default:  cnt_q <= '0;
      endcase
    end
  end

  // Next state, RAM port drive and completion routing to the owner.
  always_comb begin
    state_d            = state_q;
    done               = 1'b0;
    err                = 1'b0;
    rdata              = '0;
    bus.ram_rw_cen_o   = 1'b0;
    bus.ram_rw_wen_o   = 1'b0;
    bus.ram_rw_addr_o  = addr_q;
    bus.ram_rw_wdata_o = wdata_q;
    bus.ram_rw_size_o  = size_q;
    bus.ifu_ready_o    = 1'b0;
    bus.ifu_data_o     = '0;
    bus.ifu_err_o      = 1'b0;
    bus.lsu_ready_o    = 1'b0;
    bus.lsu_data_o     = '0;
    bus.lsu_err_o      = 1'b0;

    case (state_q)
      ARB_IDLE: if (pick_any) state_d = ARB_REQ;
      ARB_REQ: begin
        bus.ram_rw_cen_o = 1'b1;
        bus.ram_rw_wen_o = wen_q;
        state_d          = ARB_WAIT;
      end
      ARB_WAIT: begin
        // Memory ready wins over a timeout landing in the same cycle.
        if (bus.ram_rw_ready_i) begin
          done    = 1'b1;
          rdata   = bus.ram_rw_data_i;
          state_d = ARB_IDLE;
        end else if (timeout_hit) begin
          done    = 1'b1;
          err     = 1'b1;
          state_d = ARB_IDLE;
        end
      end
      default: state_d = ARB_IDLE;
    endcase

    if (owner_q == ARB_OWN_LSU) begin
      bus.lsu_ready_o = done;
      bus.lsu_data_o  = rdata;
      bus.lsu_err_o   = err;
    end else begin
      bus.ifu_ready_o = done;
      bus.ifu_data_o  = rdata;
      bus.ifu_err_o   = err;
    end
  end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter. Inputs change on the falling edge and
// outputs are sampled 1ns later; a small memory model answers one cycle
// after each enable when mem_respond is set, and stale_pulse injects a lone
// ready one cycle later regardless of the port.
module tb_ram_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mem_respond = 1'b0;
  logic        stale_pulse = 1'b0;
  logic [63:0] mem_rdata = '0;

  int unsigned n_checks = 0;
  int unsigned n_pass = 0;

  int          en_cnt;
  int          irdy_cnt;
  int          lrdy_cnt;
  int          en_cyc [4];
  logic [63:0] en_addr [4];
  int          first_rdy;
  logic        t_err;
  logic [63:0] t_data;

  ram_port_arbiter_if bus ();

  ram_port_arbiter #(.TIMEOUT(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    bus.ram_rw_ready_i <= (mem_respond && bus.ram_rw_cen_o) || stale_pulse;
    bus.ram_rw_data_i  <= mem_rdata;
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic clear_reqs();
    bus.ifu_valid_i = 1'b0;
    bus.ifu_addr_i  = '0;
    bus.lsu_valid_i = 1'b0;
    bus.lsu_wen_i   = 1'b0;
    bus.lsu_addr_i  = '0;
    bus.lsu_wdata_i = '0;
    bus.lsu_size_i  = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    clear_reqs();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    clear_reqs();

    // Reset state: every output 0.
    do_reset();
    #1;
    check_eq("rst_cen",   bus.ram_rw_cen_o, 0);
    check_eq("rst_wen",   bus.ram_rw_wen_o, 0);
    check_eq("rst_addr",  bus.ram_rw_addr_o, 0);
    check_eq("rst_wdata", bus.ram_rw_wdata_o, 0);
    check_eq("rst_size",  bus.ram_rw_size_o, 0);
    check_eq("rst_irdy",  bus.ifu_ready_o, 0);
    check_eq("rst_lrdy",  bus.lsu_ready_o, 0);

    // IFU alone.
    mem_respond = 1'b1;
    mem_rdata   = 64'h1122_3344_5566_7788;
    @(negedge clk);
    bus.ifu_valid_i = 1'b1;
    bus.ifu_addr_i  = 64'h8000_0010;
    #1 check_eq("t1_n_cen", bus.ram_rw_cen_o, 0);
    @(negedge clk); #1;
    check_eq("t1_n1_cen",   bus.ram_rw_cen_o, 1);
    check_eq("t1_n1_wen",   bus.ram_rw_wen_o, 0);
    check_eq("t1_n1_addr",  bus.ram_rw_addr_o, 64'h8000_0010);
    check_eq("t1_n1_size",  bus.ram_rw_size_o, 3);
    check_eq("t1_n1_wdata", bus.ram_rw_wdata_o, 0);
    check_eq("t1_n1_irdy",  bus.ifu_ready_o, 0);
    @(negedge clk); #1;
    check_eq("t1_n2_cen",   bus.ram_rw_cen_o, 0);
    check_eq("t1_n2_irdy",  bus.ifu_ready_o, 1);
    check_eq("t1_n2_idata", bus.ifu_data_o, 64'h1122_3344_5566_7788);
    check_eq("t1_n2_ierr",  bus.ifu_err_o, 0);
    check_eq("t1_n2_lrdy",  bus.lsu_ready_o, 0);
    check_eq("t1_n2_ldata", bus.lsu_data_o, 0);
    @(negedge clk);
    bus.ifu_valid_i = 1'b0;
    #1;
    check_eq("t1_n3_irdy", bus.ifu_ready_o, 0);
    check_eq("t1_n3_addr_hold", bus.ram_rw_addr_o, 64'h8000_0010);

    // Both valid after reset: LSU store first, then IFU.
    do_reset();
    mem_rdata = 64'hA5A5_0000_1234_5678;
    bus.ifu_valid_i = 1'b1;
    bus.ifu_addr_i  = 64'h8000_0000;
    bus.lsu_valid_i = 1'b1;
    bus.lsu_wen_i   = 1'b1;
    bus.lsu_addr_i  = 64'h8000_1000;
    bus.lsu_wdata_i = 64'hDEAD;
    bus.lsu_size_i  = 3'd3;
    @(negedge clk); #1;
    check_eq("t2_n1_cen",   bus.ram_rw_cen_o, 1);
    check_eq("t2_n1_wen",   bus.ram_rw_wen_o, 1);
    check_eq("t2_n1_addr",  bus.ram_rw_addr_o, 64'h8000_1000);
    check_eq("t2_n1_wdata", bus.ram_rw_wdata_o, 64'hDEAD);
    check_eq("t2_n1_size",  bus.ram_rw_size_o, 3);
    @(negedge clk); #1;
    check_eq("t2_n2_lrdy", bus.lsu_ready_o, 1);
    check_eq("t2_n2_lerr", bus.lsu_err_o, 0);
    check_eq("t2_n2_irdy", bus.ifu_ready_o, 0);
    @(negedge clk);
    bus.lsu_valid_i = 1'b0;
    #1 check_eq("t2_n3_cen", bus.ram_rw_cen_o, 0);
    @(negedge clk); #1;
    check_eq("t2_n4_cen",   bus.ram_rw_cen_o, 1);
    check_eq("t2_n4_wen",   bus.ram_rw_wen_o, 0);
    check_eq("t2_n4_addr",  bus.ram_rw_addr_o, 64'h8000_0000);
    check_eq("t2_n4_wdata", bus.ram_rw_wdata_o, 0);
    @(negedge clk); #1;
    check_eq("t2_n5_irdy",  bus.ifu_ready_o, 1);
    check_eq("t2_n5_idata", bus.ifu_data_o, 64'hA5A5_0000_1234_5678);
    check_eq("t2_n5_lrdy",  bus.lsu_ready_o, 0);
    @(negedge clk);
    bus.ifu_valid_i = 1'b0;

    // Sustained contention for 12 cycles: LSU, IFU, LSU, IFU.
    @(negedge clk);
    bus.ifu_valid_i = 1'b1;
    bus.ifu_addr_i  = 64'h8000_0100;
    bus.lsu_valid_i = 1'b1;
    bus.lsu_wen_i   = 1'b0;
    bus.lsu_addr_i  = 64'h8000_0200;
    bus.lsu_wdata_i = '0;
    en_cnt = 0; irdy_cnt = 0; lrdy_cnt = 0;
    for (int c = 0; c < 12; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      if (bus.ram_rw_cen_o) begin
        if (en_cnt < 4) begin
          en_cyc[en_cnt]  = c;
          en_addr[en_cnt] = bus.ram_rw_addr_o;
        end
        en_cnt++;
      end
      if (bus.ifu_ready_o) irdy_cnt++;
      if (bus.lsu_ready_o) lrdy_cnt++;
    end
    @(negedge clk);
    clear_reqs();
    check_eq("t3_en_count", 64'(en_cnt), 4);
    check_eq("t3_irdy_count", 64'(irdy_cnt), 2);
    check_eq("t3_lrdy_count", 64'(lrdy_cnt), 2);
    for (int k = 0; k < 4; k++) begin
      check_eq($sformatf("t3_en%0d_cyc", k), 64'(en_cyc[k]), 64'(1 + 3 * k));
      check_eq($sformatf("t3_en%0d_addr", k), en_addr[k],
               (k % 2 == 0) ? 64'h8000_0200 : 64'h8000_0100);
    end

    // LSU load with no memory response: timeout error at N+17.
    mem_respond = 1'b0;
    mem_rdata   = 64'hFEED_FACE_CAFE_BEEF;
    @(negedge clk);
    bus.lsu_valid_i = 1'b1;
    bus.lsu_wen_i   = 1'b0;
    bus.lsu_addr_i  = 64'h8000_2000;
    bus.lsu_size_i  = 3'd3;
    first_rdy = -1; t_err = 1'b0; t_data = '0;
    for (int c = 0; c < 40 && first_rdy < 0; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      if (bus.lsu_ready_o) begin
        first_rdy = c;
        t_err     = bus.lsu_err_o;
        t_data    = bus.lsu_data_o;
      end
    end
    check_eq("t4_to_cycle", 64'(first_rdy), 17);
    check_eq("t4_to_err",   t_err, 1);
    check_eq("t4_to_data",  t_data, 0);
    @(negedge clk);
    clear_reqs();
    mem_respond = 1'b1;
    mem_rdata   = 64'h0BAD_F00D_0000_0001;
    @(negedge clk);
    bus.ifu_valid_i = 1'b1;
    bus.ifu_addr_i  = 64'h8000_0040;
    @(negedge clk); #1 check_eq("t4_after_cen", bus.ram_rw_cen_o, 1);
    @(negedge clk); #1;
    check_eq("t4_after_irdy",  bus.ifu_ready_o, 1);
    check_eq("t4_after_ierr",  bus.ifu_err_o, 0);
    check_eq("t4_after_idata", bus.ifu_data_o, 64'h0BAD_F00D_0000_0001);
    @(negedge clk);
    clear_reqs();

    // Ready arriving exactly on the last timeout cycle is a success.
    mem_respond = 1'b0;
    mem_rdata   = 64'h1357_9BDF_2468_ACE0;
    @(negedge clk);
    bus.lsu_valid_i = 1'b1;
    bus.lsu_addr_i  = 64'h8000_3000;
    bus.lsu_size_i  = 3'd2;
    repeat (16) @(negedge clk);
    stale_pulse = 1'b1;
    #1 check_eq("t7_n16_lrdy", bus.lsu_ready_o, 0);
    @(negedge clk);
    stale_pulse = 1'b0;
    #1;
    check_eq("t7_n17_lrdy",  bus.lsu_ready_o, 1);
    check_eq("t7_n17_lerr",  bus.lsu_err_o, 0);
    check_eq("t7_n17_ldata", bus.lsu_data_o, 64'h1357_9BDF_2468_ACE0);
    @(negedge clk);
    clear_reqs();

    // Reset during WAIT, memory ready arriving right after: ignored.
    @(negedge clk);
    bus.ifu_valid_i = 1'b1;
    bus.ifu_addr_i  = 64'h8000_3000;
    @(negedge clk); #1 check_eq("t5_n1_cen", bus.ram_rw_cen_o, 1);
    @(negedge clk);
    rst_n = 1'b0;
    stale_pulse = 1'b1;
    bus.ifu_valid_i = 1'b0;
    #1 check_eq("t5_n2_irdy", bus.ifu_ready_o, 0);
    @(negedge clk);
    rst_n = 1'b1;
    stale_pulse = 1'b0;
    #1;
    check_eq("t5_n3_irdy",  bus.ifu_ready_o, 0);
    check_eq("t5_n3_lrdy",  bus.lsu_ready_o, 0);
    check_eq("t5_n3_idata", bus.ifu_data_o, 0);
    check_eq("t5_n3_cen",   bus.ram_rw_cen_o, 0);
    check_eq("t5_n3_addr",  bus.ram_rw_addr_o, 0);
    check_eq("t5_n3_size",  bus.ram_rw_size_o, 0);
    mem_respond = 1'b1;
    mem_rdata   = 64'h7777_0000_8888_0000;
    @(negedge clk);
    bus.ifu_valid_i = 1'b1;
    bus.ifu_addr_i  = 64'h8000_0080;
    @(negedge clk); #1;
    check_eq("t5_re_cen",  bus.ram_rw_cen_o, 1);
    check_eq("t5_re_addr", bus.ram_rw_addr_o, 64'h8000_0080);
    @(negedge clk); #1;
    check_eq("t5_re_irdy",  bus.ifu_ready_o, 1);
    check_eq("t5_re_idata", bus.ifu_data_o, 64'h7777_0000_8888_0000);
    @(negedge clk);
    clear_reqs();

    // Stale ready while idle with no requests.
    stale_pulse = 1'b1;
    #1 check_eq("t6_m_cen", bus.ram_rw_cen_o, 0);
    @(negedge clk);
    stale_pulse = 1'b0;
    #1;
    check_eq("t6_m1_irdy", bus.ifu_ready_o, 0);
    check_eq("t6_m1_lrdy", bus.lsu_ready_o, 0);
    check_eq("t6_m1_cen",  bus.ram_rw_cen_o, 0);
    @(negedge clk); #1;
    check_eq("t6_m2_cen",  bus.ram_rw_cen_o, 0);
    check_eq("t6_m2_irdy", bus.ifu_ready_o, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
